vga_sync_decoder: RTL and testbench
===================================

# vga_sync_decoder

Receive-side counterpart of the VGA timing generator. It samples `h_sync`, `v_sync` and `video_on` on the pixel clock and regenerates `pixel_x`, `pixel_y` and a data-enable from the sync edges alone. It also checks line and frame timing against 640x480@60 and reports lock and error status. It sits beside the VGA output path in the top level as an on-chip timing monitor and frame-capture front end.

## Interface
- `H_VISIBLE`, 640, active pixels per line
- `H_SYNC`, 96, hsync low width in samples
- `H_BACK`, 48, back porch in samples
- `H_TOTAL`, 800, samples per line
- `V_VISIBLE`, 480, active lines
- `V_SYNC`, 2, vsync width in lines
- `V_BACK`, 33, back porch in lines
- `V_TOTAL`, 525, lines per frame
- `clk` input 1: 25 MHz pixel clock; the only clock
- `rst` input 1: synchronous, active-high reset
- `h_sync` input 1: horizontal sync, active low
- `v_sync` input 1: vertical sync, active low
- `video_on` input 1: generator's active-video flag, cross-checked against the recovered flag
- `pixel_x` output 10: recovered column
- `pixel_y` output 10: recovered row
- `de` output 1: recovered active video; asserted only while locked
- `locked` output 1: timing is locked
- `frame_start` output 1: one-cycle pulse on each vsync start while locked
- `err` output 1: one-cycle pulse on a timing error while locked
- `err_count` output 8: number of errors, saturating at 255

## Operation
- **Previous-sample registers.** `hs_q` and `vs_q` hold the previous `h_sync` and `v_sync` samples. Both reset to 1.
- **Edge detection.**
  - hstart = `hs_q` & ~`h_sync`.
  - hend = ~`hs_q` & `h_sync`.
  - vstart = `vs_q` & ~`v_sync`.
- **Sample index `s` (11 bit).**
  - s = 0 on hstart; otherwise s increments each cycle.
  - s saturates at 2047.
- **Line index `L` (10 bit).**
  - L = 0 on vstart.
  - Otherwise L increments on hstart, saturating at 1023.
  - If vstart and hstart fall in the same cycle, vstart wins.
- **Visibility and coordinates.**
  - visible = s in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE-1], i.e. [144, 783].
  - AND L in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VISIBLE-1], i.e. [35, 514].
  - pixel_x = s-144 and pixel_y = L-35 when visible; otherwise both are 0.
- **Timing errors.** Each is evaluated on the current sample:
  - hstart with previous s ≠ H_TOTAL-1;
  - s reaching H_TOTAL with no hstart (missing hsync), flagged once per occurrence;
  - hend with s ≠ H_SYNC;
  - vstart with previous L ≠ V_TOTAL-1;
  - L reaching V_TOTAL (missing vsync);
  - `video_on` ≠ visible. This check applies in LOCKED only.
- **Lock FSM.** States are SEARCH, ACQUIRE and LOCKED.
  - SEARCH: errors are ignored. vstart moves to ACQUIRE.
  - ACQUIRE: any error moves to SEARCH, with no `err` pulse and no count. A vstart with no error since entry moves to LOCKED.
  - LOCKED: any error moves to SEARCH, pulses `err` and increments `err_count`. vstart pulses `frame_start`.
  - If vstart and an error occur in the same cycle, the error takes priority.
- `locked` = (state == LOCKED). `de` = visible & locked.

## Timing
- All outputs are registered. An output at cycle t+1 describes the input sample at cycle t, so latency is 1 cycle.
- Reset values:
  - all outputs 0;
  - state = SEARCH;
  - s = 2047, L = 1023, so the first edges after reset do not count as valid periods.
- Reset mid-frame: the decoder returns to SEARCH and drops `locked` the next cycle. `err_count` clears.
- `err` and `frame_start` are never high for two consecutive cycles.
- Minimum lock time from a clean stream is 1 frame plus 1 cycle after the first vstart, provided hsync has been running for at least 1 line before it.

## Structure
- Shared package `pacman_vga_pkg` holds:
  - the 640x480 timing constants, which are also used by `vga_controller`;
  - the `lock_state_t` enum: SEARCH, ACQUIRE, LOCKED.
- Sub-module `vga_sync_edge`: the input sampling register plus hstart/hend/vstart pulse generation, instantiated once.
- The counters, checks and FSM stay in the top of this block.

## Test plan
- **Clean lock.** Reset, then a clean 640x480 stream starting mid-frame → `locked` = 1 one cycle after the second vstart. `err_count` = 0. `frame_start` pulses once per 420000 cycles.
- **Coordinate recovery.** While locked, check the sample at s = 144 on line L = 35 → one cycle later `pixel_x` = 0, `pixel_y` = 0, `de` = 1. At s = 783 on L = 514 → `pixel_x` = 639, `pixel_y` = 479. At s = 784 → `de` = 0.
- **Short line.** While locked, inject one 799-sample line → `err` pulses once, `err_count` = 1, `locked` = 0. Relock after the next clean vstart-to-vstart frame.
- **Bad hsync width.** While locked, drive hsync low for 95 samples → error at hend; `err_count` increments.
- **Missing vsync and saturation.** Hold `v_sync` high for 2 frames → error when L reaches 525. Separately, force 300 errors → `err_count` stays at 255.
- **Flag mismatch and reset.** Drive `video_on` = 0 at s = 200, L = 100 while locked → `err` pulses. Assert `rst` mid-frame → next cycle all outputs are 0 and state is SEARCH.

Source files
------------

// File: rtl/pacman_vga_pkg.sv
// Shared 640x480@60 timing constants and lock-state encoding for the VGA
// generator and the sync decoder.
package pacman_vga_pkg;

   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BACK    = 48;
   localparam int VGA_H_TOTAL   = 800;
   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BACK    = 33;
   localparam int VGA_V_TOTAL   = 525;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } lock_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Samples the active-low sync inputs and produces single-cycle
// hsync start/end and vsync start strobes for the current sample.
module vga_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic h_sync_i,
   input  logic v_sync_i,
   output logic hstart_o,
   output logic hend_o,
   output logic vstart_o
);

   logic hs_q, vs_q;

   // Idle-high reset so a sync already low at reset release reads as an edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hs_q <= 1'b1;
         vs_q <= 1'b1;
      end else begin
         hs_q <= h_sync_i;
         vs_q <= v_sync_i;
      end
   end

   assign hstart_o = hs_q & ~h_sync_i;
   assign hend_o   = ~hs_q & h_sync_i;
   assign vstart_o = vs_q & ~v_sync_i;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and data-enable from VGA sync edges and
// monitors line/frame timing, reporting lock, errors and frame starts.
module vga_sync_decoder
   import pacman_vga_pkg::*;
#(
   parameter int H_VISIBLE = VGA_H_VISIBLE,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BACK    = VGA_H_BACK,
   parameter int H_TOTAL   = VGA_H_TOTAL,
   parameter int V_VISIBLE = VGA_V_VISIBLE,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BACK    = VGA_V_BACK,
   parameter int V_TOTAL   = VGA_V_TOTAL
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       h_sync,
   input  logic       v_sync,
   input  logic       video_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       de,
   output logic       locked,
   output logic       frame_start,
   output logic       err,
   output logic [7:0] err_count
);

   localparam logic [10:0] S_MAX  = 11'h7FF;
   localparam logic [9:0]  L_MAX  = 10'h3FF;
   localparam logic [10:0] X_LO   = 11'(H_SYNC + H_BACK);
   localparam logic [10:0] X_HI   = 11'(H_SYNC + H_BACK + H_VISIBLE - 1);
   localparam logic [9:0]  Y_LO   = 10'(V_SYNC + V_BACK);
   localparam logic [9:0]  Y_HI   = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);
   localparam logic [10:0] S_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] S_OVER = 11'(H_TOTAL);
   localparam logic [10:0] S_SYNC = 11'(H_SYNC);
   localparam logic [9:0]  L_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]  L_OVER = 10'(V_TOTAL);

   logic        hstart, hend, vstart;
   logic [10:0] s_q, s_d;
   logic [9:0]  l_q, l_d;
   lock_state_t state_q, state_d;
   logic [9:0]  px_q, px_d, py_q, py_d;
   logic        de_q, de_d, fs_q, fs_d, err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        visible, timing_err;

   vga_sync_edge u_edge (
      .clk_i    (clk),
      .rst_i    (rst),
      .h_sync_i (h_sync),
      .v_sync_i (v_sync),
      .hstart_o (hstart),
      .hend_o   (hend),
      .vstart_o (vstart)
   );

   // s_d / l_d are the sample and line index of the sample on the inputs now.
   always_comb begin
      s_d = hstart ? 11'd0 : ((s_q == S_MAX) ? S_MAX : s_q + 11'd1);
      if (vstart)
         l_d = 10'd0;
      else if (hstart && l_q != L_MAX)
         l_d = l_q + 10'd1;
      else
         l_d = l_q;
   end

   assign visible = (s_d >= X_LO) && (s_d <= X_HI) && (l_d >= Y_LO) && (l_d <= Y_HI);

   // s_d only reaches H_TOTAL by counting, so that term fires once per missing hsync.
   assign timing_err = (hstart && s_q != S_LAST)
                     || (s_d == S_OVER)
                     || (hend && s_d != S_SYNC)
                     || (vstart && l_q != L_LAST)
                     || (l_d == L_OVER && l_q != L_OVER)
                     || (state_q == LOCKED && video_on != visible);

   always_comb begin
      state_d = state_q;
      fs_d    = 1'b0;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         SEARCH: begin
            if (vstart) state_d = ACQUIRE;
         end
         ACQUIRE: begin
            if (timing_err)  state_d = SEARCH;
            else if (vstart) state_d = LOCKED;
         end
         LOCKED: begin
            if (timing_err) begin
               state_d = SEARCH;
               err_d   = 1'b1;
               if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            end else if (vstart) begin
               fs_d = 1'b1;
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   always_comb begin
      px_d = visible ? 10'(s_d - X_LO) : 10'd0;
      py_d = visible ? (l_d - Y_LO) : 10'd0;
      de_d = visible && (state_d == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q     <= S_MAX;
         l_q     <= L_MAX;
         state_q <= SEARCH;
         px_q    <= '0;
         py_q    <= '0;
         de_q    <= 1'b0;
         fs_q    <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         s_q     <= s_d;
         l_q     <= l_d;
         state_q <= state_d;
         px_q    <= px_d;
         py_q    <= py_d;
         de_q    <= de_d;
         fs_q    <= fs_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pixel_x     = px_q;
   assign pixel_y     = py_q;
   assign de          = de_q;
   assign locked      = (state_q == LOCKED);
   assign frame_start = fs_q;
   assign err         = err_q;
   assign err_count   = cnt_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboarded random-stream bench for vga_sync_decoder on a reduced raster.
module tb_vga_sync_decoder;

   localparam int HV = 6, HS = 2, HB = 2, HT = 12;
   localparam int VV = 4, VS = 2, VB = 1, VT = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1, h_sync = 1'b1, v_sync = 1'b1, video_on = 1'b0;
   logic [9:0] pixel_x, pixel_y;
   logic       de, locked, frame_start, err;
   logic [7:0] err_count;

   vga_sync_decoder #(
      .H_VISIBLE(HV), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
      .V_VISIBLE(VV), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT)
   ) dut (
      .clk(clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync), .video_on(video_on),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .de(de), .locked(locked),
      .frame_start(frame_start), .err(err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0] px;
      logic [9:0] py;
      logic       de;
      logic       lk;
      logic       fs;
      logic       er;
      logic [7:0] cnt;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0, errors = 0;

   // Reference model: s as time since last hsync fall, L as hsync falls since vsync fall.
   int t = 0, t_hs = -100000, lines = 1023, m_mode = 0, m_cnt = 0;
   bit p_h = 1'b1, p_v = 1'b1;

   task automatic model(input bit r, input bit h, input bit v, input bit vo, output obs_t o);
      int s, s_prev, l, l_prev;
      bit hst, hen, vst, vis, bad;
      o = '0;
      t++;
      if (r) begin
         t_hs = t - 100000; lines = 1023; m_mode = 0; m_cnt = 0; p_h = 1'b1; p_v = 1'b1;
         return;
      end
      hst = p_h && !h;
      hen = !p_h && h;
      vst = p_v && !v;
      s_prev = (t - 1 - t_hs > 2047) ? 2047 : t - 1 - t_hs;
      if (hst) t_hs = t;
      s = (t - t_hs > 2047) ? 2047 : t - t_hs;
      l_prev = lines;
      if (vst) lines = 0;
      else if (hst && lines < 1023) lines++;
      l = lines;
      vis = (s >= HS + HB) && (s < HS + HB + HV) && (l >= VS + VB) && (l < VS + VB + VV);
      bad = (hst && s_prev != HT - 1) || (s == HT) || (hen && s != HS)
         || (vst && l_prev != VT - 1) || (l == VT && l_prev != VT)
         || (m_mode == 2 && vo != vis);
      case (m_mode)
         0: if (vst) m_mode = 1;
         1: begin
            if (bad) m_mode = 0;
            else if (vst) m_mode = 2;
         end
         default: begin
            if (bad) begin
               m_mode = 0; o.er = 1'b1;
               if (m_cnt < 255) m_cnt++;
            end else if (vst) o.fs = 1'b1;
         end
      endcase
      p_h = h;
      p_v = v;
      o.lk  = (m_mode == 2);
      o.de  = vis && o.lk;
      o.px  = vis ? 10'(s - HS - HB) : 10'd0;
      o.py  = vis ? 10'(l - VS - VB) : 10'd0;
      o.cnt = 8'(m_cnt);
   endtask

   task automatic drive(input bit r, input bit h, input bit v, input bit vo);
      obs_t o;
      @(negedge clk);
      rst = r; h_sync = h; v_sync = v; video_on = vo;
      model(r, h, v, vo, o);
      exp_q.push_back(o);
   endtask

   // Monitor: every registered output sample is matched against the model.
   always @(posedge clk) begin
      obs_t e, g;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = '{px: pixel_x, py: pixel_y, de: de, lk: locked, fs: frame_start, er: err, cnt: err_count};
         checks++;
         if (g !== e) begin
            errors++;
            if (errors <= 20)
               $display("FAIL scoreboard t=%0t got px=%0d py=%0d de=%0b lk=%0b fs=%0b er=%0b cnt=%0d exp px=%0d py=%0d de=%0b lk=%0b fs=%0b er=%0b cnt=%0d",
                        $time, g.px, g.py, g.de, g.lk, g.fs, g.er, g.cnt,
                        e.px, e.py, e.de, e.lk, e.fs, e.er, e.cnt);
         end
      end
   end

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, want);
      end
   endtask

   int lc = 0;

   task automatic gen_line(input int x0, input bit sh, input bit nar, input bit novs,
                           input bit flip, input int flip_at);
      int len;
      bit h, v, vo;
      len = sh ? HT - 1 : HT;
      for (int x = x0; x < len; x++) begin
         h  = !(x < HS);
         v  = !(lc < VS);
         if (nar && x == HS - 1) h = 1'b1;
         if (novs) v = 1'b1;
         vo = (x >= HS + HB) && (x < HS + HB + HV) && (lc >= VS + VB) && (lc < VS + VB + VV);
         if (flip && x == flip_at) vo = !vo;
         drive(1'b0, h, v, vo);
      end
      lc = (lc + 1) % VT;
   endtask

   task automatic clean_lines(input int n);
      for (int i = 0; i < n; i++) gen_line(0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic settle;
      @(posedge clk);
      #2;
   endtask

   initial begin
      int r, nsat, guard;
      bit novs_frame;
      repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b0);

      // Clean stream entered mid-frame and mid-line.
      lc = $urandom_range(VT - 1);
      gen_line($urandom_range(HT - 1), 1'b0, 1'b0, 1'b0, 1'b0, 0);
      clean_lines(4 * VT);
      settle();
      check("clean_lock_locked", int'(locked), 1);
      check("clean_lock_err_count", int'(err_count), 0);

      // Random timing faults, missing vsync frames and occasional resets.
      novs_frame = 1'b0;
      for (int i = 0; i < 40 * VT; i++) begin
         if (lc == 0) novs_frame = ($urandom_range(5) == 0);
         r = $urandom_range(15);
         if ($urandom_range(199) == 0) drive(1'b1, 1'b1, 1'b1, 1'b0);
         gen_line(0, r == 0, r == 1, novs_frame && lc < VS, r == 2, $urandom_range(HT - 1));
      end
      clean_lines(3 * VT);

      // Repeated short lines while locked drive the error counter into saturation.
      nsat = 0;
      guard = 0;
      while (nsat < 300 && guard < 6000) begin
         guard++;
         if (m_mode == 2 && lc == 1) begin
            nsat++;
            gen_line(0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
         end else begin
            clean_lines(1);
         end
      end
      settle();
      check("saturation_injected", nsat, 300);
      check("saturation_err_count", int'(err_count), 255);

      // Reset in the middle of a locked frame.
      clean_lines(2 * VT + 3);
      settle();
      check("pre_reset_locked", int'(locked), 1);
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      settle();
      check("reset_locked", int'(locked), 0);
      check("reset_err_count", int'(err_count), 0);
      check("reset_outputs", int'({pixel_x, pixel_y, de, frame_start, err}), 0);
      clean_lines(3 * VT);
      settle();
      check("relock_after_reset", int'(locked), 1);

      // Unstructured sync noise.
      for (int i = 0; i < 400; i++)
         drive(1'b0, 1'($urandom), 1'($urandom_range(7) != 0), 1'($urandom));

      repeat (2) @(posedge clk);
      #2;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
